// File: rtl/mips_pkg.sv
`default_nettype none
//============================================================================
// Module      : mips_pkg
// Description : Opcode/funct encodings, ALU operation codes and the ID/EX
//               control bundle shared by the decode stage.
// Revision    : 1.0 - initial release
//============================================================================
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SLL = 3'b100,
        ALU_SRL = 3'b101,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    // Control half of the ID/EX pipeline register; an all-zero value is a bubble.
    typedef struct packed {
        logic    valid;
        logic    reg_write;
        logic    mem_to_reg;
        logic    mem_write;
        logic    alu_src;
        logic    reg_dst;
        logic    link;
        alu_op_e alu_ctrl;
    } idex_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/regfile_wt.sv
`default_nettype none
//============================================================================
// Module      : regfile_wt
// Description : Two-read/one-write register file. Register 0 is hard-wired
//               to zero; a read of the address being written this cycle
//               returns the write data (write-through).
// Revision    : 1.0 - initial release
//============================================================================
module regfile_wt #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we_i,
    input  logic [AW-1:0]   wa_i,
    input  logic [XLEN-1:0] wd_i,
    input  logic [AW-1:0]   ra1_i,
    input  logic [AW-1:0]   ra2_i,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o
);

    logic [XLEN-1:0] regs_q [NREG];

    // Storage: cleared on reset, writes to register 0 are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != '0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    // Read ports with zero register and same-cycle write bypass.
    always_comb begin
        rd1_o = regs_q[ra1_i];
        rd2_o = regs_q[ra2_i];
        if (ra1_i == '0)                   rd1_o = '0;
        else if (we_i && (wa_i == ra1_i))  rd1_o = wd_i;
        if (ra2_i == '0)                   rd2_o = '0;
        else if (we_i && (wa_i == ra2_i))  rd2_o = wd_i;
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
//============================================================================
// Module      : decode_stage
// Description : MIPS-subset instruction decode with early branch resolution,
//               ID/EX pipeline register, and idle-driven sticky halt.
// Revision    : 1.0 - initial release
//============================================================================
module decode_stage
    import mips_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NREG       = 32,
    parameter int HALT_COUNT = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              instr_d,
    input  logic [XLEN-1:0]          pc_plus4_d,
    input  logic                     valid_d,
    input  logic                     stall_e,
    input  logic                     flush_e,
    input  logic                     fwd_a_d,
    input  logic                     fwd_b_d,
    input  logic [XLEN-1:0]          alu_out_m,
    input  logic                     reg_write_w,
    input  logic [$clog2(NREG)-1:0]  write_reg_w,
    input  logic [XLEN-1:0]          result_w,
    output logic                     valid_e,
    output logic                     reg_write_e,
    output logic                     mem_to_reg_e,
    output logic                     mem_write_e,
    output logic                     alu_src_e,
    output logic                     reg_dst_e,
    output logic                     link_e,
    output logic [2:0]               alu_ctrl_e,
    output logic [$clog2(NREG)-1:0]  rs_e,
    output logic [$clog2(NREG)-1:0]  rt_e,
    output logic [$clog2(NREG)-1:0]  rd_e,
    output logic [4:0]               shamt_e,
    output logic [XLEN-1:0]          rd1_e,
    output logic [XLEN-1:0]          rd2_e,
    output logic [XLEN-1:0]          imm_e,
    output logic                     pc_src_d,
    output logic [XLEN-1:0]          pc_branch_d,
    output logic                     branch_d,
    output logic                     illegal_d,
    output logic                     halt
);

    localparam int AW = $clog2(NREG);
    localparam int CW = $clog2(HALT_COUNT + 1);

    typedef struct packed {
        idex_ctrl_t      ctrl;
        logic [AW-1:0]   rs;
        logic [AW-1:0]   rt;
        logic [AW-1:0]   rd;
        logic [4:0]      shamt;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
    } idex_t;

    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic [AW-1:0]   rs_addr;
    logic [AW-1:0]   rt_addr;
    logic [XLEN-1:0] rf_rd1;
    logic [XLEN-1:0] rf_rd2;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] imm_sext;
    logic [XLEN-1:0] imm_ext;
    idex_ctrl_t      ctrl;
    logic            legal;
    logic            zero_ext;
    logic            is_beq, is_bne, is_j, is_jal, is_jr;
    logic            equal;
    idex_t           load_val;
    idex_t           idex_d, idex_q;
    logic [CW-1:0]   idle_d, idle_q;
    logic            halt_d, halt_q;

    assign opcode  = instr_d[31:26];
    assign funct   = instr_d[5:0];
    assign rs_addr = AW'(instr_d[25:21]);
    assign rt_addr = AW'(instr_d[20:16]);

    regfile_wt #(
        .XLEN (XLEN),
        .NREG (NREG),
        .AW   (AW)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we_i  (reg_write_w),
        .wa_i  (write_reg_w),
        .wd_i  (result_w),
        .ra1_i (rs_addr),
        .ra2_i (rt_addr),
        .rd1_o (rf_rd1),
        .rd2_o (rf_rd2)
    );

    // Main decoder: control bundle, legality and control-transfer class.
    always_comb begin
        ctrl     = '0;
        legal    = 1'b1;
        zero_ext = 1'b0;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        is_j     = 1'b0;
        is_jal   = 1'b0;
        is_jr    = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                case (funct)
                    FN_ADD: ctrl.alu_ctrl = ALU_ADD;
                    FN_SUB: ctrl.alu_ctrl = ALU_SUB;
                    FN_AND: ctrl.alu_ctrl = ALU_AND;
                    FN_OR:  ctrl.alu_ctrl = ALU_OR;
                    FN_SLT: ctrl.alu_ctrl = ALU_SLT;
                    FN_SLL: ctrl.alu_ctrl = ALU_SLL;
                    FN_SRL: ctrl.alu_ctrl = ALU_SRL;
                    FN_JR: begin
                        ctrl.reg_write = 1'b0;
                        ctrl.reg_dst   = 1'b0;
                        is_jr          = 1'b1;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_ADDI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = ALU_ADD;
            end
            OP_ANDI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = ALU_AND;
                zero_ext       = 1'b1;
            end
            OP_ORI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = ALU_OR;
                zero_ext       = 1'b1;
            end
            OP_SLTI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = ALU_SLT;
            end
            OP_LW: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.alu_ctrl   = ALU_ADD;
            end
            OP_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = ALU_ADD;
            end
            OP_BEQ: begin
                is_beq        = 1'b1;
                ctrl.alu_ctrl = ALU_SUB;
            end
            OP_BNE: begin
                is_bne        = 1'b1;
                ctrl.alu_ctrl = ALU_SUB;
            end
            OP_J:   is_j = 1'b1;
            OP_JAL: begin
                is_jal         = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                ctrl.link      = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    assign imm_sext = {{(XLEN-16){instr_d[15]}}, instr_d[15:0]};
    assign imm_ext  = zero_ext ? {{(XLEN-16){1'b0}}, instr_d[15:0]} : imm_sext;

    // Early branch resolution on forwarded compare operands.
    assign src_a     = fwd_a_d ? alu_out_m : rf_rd1;
    assign src_b     = fwd_b_d ? alu_out_m : rf_rd2;
    assign equal     = (src_a == src_b);
    assign pc_src_d  = valid_d & ((is_beq & equal) | (is_bne & ~equal) | is_j | is_jal | is_jr);
    assign branch_d  = valid_d & (is_beq | is_bne | is_j | is_jal | is_jr);
    assign illegal_d = valid_d & ~legal;

    // Redirect target: register for JR, pseudo-direct for J/JAL, PC-relative otherwise.
    always_comb begin
        pc_branch_d = pc_plus4_d + {imm_sext[XLEN-3:0], 2'b00};
        if (is_jr)
            pc_branch_d = src_a;
        else if (is_j || is_jal)
            pc_branch_d = {pc_plus4_d[XLEN-1:28], instr_d[25:0], 2'b00};
    end

    // ID/EX next state: flush beats stall beats load; invalid/illegal load a bubble.
    always_comb begin
        load_val               = '0;
        load_val.ctrl          = ctrl;
        load_val.ctrl.valid    = 1'b1;
        load_val.rs            = rs_addr;
        load_val.rt            = rt_addr;
        load_val.rd            = AW'(instr_d[15:11]);
        load_val.shamt         = instr_d[10:6];
        load_val.rd1           = rf_rd1;
        load_val.rd2           = rf_rd2;
        load_val.imm           = imm_ext;
        if (is_jal) begin
            load_val.rd  = AW'(NREG - 1);
            load_val.rd1 = pc_plus4_d;
        end
        if (flush_e)
            idex_d = '0;
        else if (stall_e)
            idex_d = idex_q;
        else if (valid_d && legal)
            idex_d = load_val;
        else
            idex_d = '0;
    end

    // Idle counter saturates at HALT_COUNT; halt latches one cycle after it gets there.
    always_comb begin
        idle_d = idle_q;
        if (valid_d)
            idle_d = '0;
        else if (!stall_e && (idle_q != CW'(HALT_COUNT)))
            idle_d = idle_q + 1'b1;
        halt_d = halt_q | (idle_q == CW'(HALT_COUNT));
    end

    // Pipeline register, idle counter and halt flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q <= '0;
            idle_q <= '0;
            halt_q <= 1'b0;
        end else begin
            idex_q <= idex_d;
            idle_q <= idle_d;
            halt_q <= halt_d;
        end
    end

    assign valid_e      = idex_q.ctrl.valid;
    assign reg_write_e  = idex_q.ctrl.reg_write;
    assign mem_to_reg_e = idex_q.ctrl.mem_to_reg;
    assign mem_write_e  = idex_q.ctrl.mem_write;
    assign alu_src_e    = idex_q.ctrl.alu_src;
    assign reg_dst_e    = idex_q.ctrl.reg_dst;
    assign link_e       = idex_q.ctrl.link;
    assign alu_ctrl_e   = idex_q.ctrl.alu_ctrl;
    assign rs_e         = idex_q.rs;
    assign rt_e         = idex_q.rt;
    assign rd_e         = idex_q.rd;
    assign shamt_e      = idex_q.shamt;
    assign rd1_e        = idex_q.rd1;
    assign rd2_e        = idex_q.rd2;
    assign imm_e        = idex_q.imm;
    assign halt         = halt_q;

endmodule
`default_nettype wire
